int_controller: RTL and testbench
=================================

Name: int_controller

Overview:
- Interrupt controller between the interrupt sources (the periodic timer tick and three external request lines) and the single-cycle CPU's interrupt entry/exit logic.
- Captures rising edges into pending bits and applies a CPU-written mask.
- Presents one prioritised request with its source ID, then holds off further requests until the CPU signals handler completion.
- Completes the interrupt path in the reverse direction: the CPU consumes requests and returns take/finish handshakes; this block generates the requests and responds to those handshakes.

Parameters:
- NSRC, 4, number of interrupt sources (fixed at 4 for this revision; ID width 2).
- MASK_RST, 4'b0001, mask value after reset (only the timer is enabled).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- src  input  4  raw request lines; bit0 = timer tick, bits 1..3 = external. Synchronous to clk.
- we_mask  input  1  CPU port write strobe targeting the mask register.
- mask_in  input  4  new mask value, sampled when we_mask=1.
- irq_take  input  1  CPU has vectored to the handler this cycle (one-cycle pulse).
- irq_done  input  1  CPU finish-interrupt (return) strobe, one cycle.
- irq  output  1  interrupt request to CPU.
- irq_id  output  2  ID of the requested/serviced source.
- pending  output  4  pending register, readable via a CPU input port.
- mask  output  4  current mask register.
- overflow  output  4  sticky per-source flag: edge arrived while that source was already pending.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, irq=0, irq_id=0, pending=0, overflow=0, mask=MASK_RST.
  - Edge-detect history register = 0, so a source that is high at reset release registers one edge on the first clock.
- Edge capture:
  - prev <= src every cycle; edge = src & ~prev.
  - An edge on source i sets pending[i] next cycle regardless of mask; masking only gates requesting.
  - Edge on i while pending[i]=1 -> overflow[i] <= 1 (sticky until reset); pending stays 1, with no counting.
- Mask:
  - we_mask=1 -> mask <= mask_in next cycle. Takes effect for arbitration from the following cycle.
  - Masking a source whose request is already presented does not withdraw irq.
- Arbitration: eligible = pending & mask; fixed priority, lowest index wins (timer highest).
- FSM:
  - IDLE: if eligible!=0 -> REQ; irq <= 1, irq_id <= winning index (registered, so 1 cycle after the pending bit is visible).
  - REQ: irq and irq_id held stable. On irq_take=1 -> SERVICE; pending[irq_id] cleared, irq <= 0, irq_id held.
  - SERVICE: no new request issued; edges keep accumulating in pending. On irq_done=1 -> IDLE.
  - IDLE re-arbitrates the next cycle, so a back-to-back interrupt gives irq=1 two cycles after irq_done.
- Simultaneous events:
  - Edge on i in the same cycle that take clears pending[i] -> pending[i] ends at 1 (set wins); overflow is not set.
  - irq_done in IDLE or REQ and irq_take in IDLE or SERVICE are ignored.
  - irq_take and irq_done together in REQ: take is honoured, done is ignored.
- Latency: src edge at cycle n -> pending at n+1 -> irq at n+2.
- No nesting; a single level of service.

Test Plan:
1. Reset, then src[0] pulse at cycle 5 -> pending=0001 at 6, irq=1 and irq_id=0 at 7; irq_take at 9 -> irq=0, pending=0000 at 10; irq_done at 12 -> state IDLE.
2. mask=1111 written; src[3] and src[1] rise in the same cycle -> irq_id=1 first. After take and done, irq=1 with irq_id=3 two cycles after done.
3. src[2] edge with mask=0001 -> pending=0100, irq stays 0. Write mask=0101 -> irq=1 with irq_id=2 two cycles after we_mask.
4. Two src[0] pulses while pending[0]=1 -> overflow=0001. Edge on src[0] in the same cycle as irq_take of ID 0 -> pending[0]=1 and overflow unchanged.
5. During SERVICE, src[0] edge -> irq stays 0 until irq_done. Stray irq_done in IDLE and stray irq_take in SERVICE -> no state change.
6. reset asserted low mid-REQ (asynchronously, between clock edges) -> irq=0, pending=0, mask=0001 immediately. src held high across release -> one edge captured, irq at 2nd clock after release.

Source files
------------

// File: rtl/int_controller.sv
//==============================================================================
// Module   : int_controller
// Purpose  : Edge-capturing, maskable, fixed-priority interrupt controller with
//            a take/done handshake toward a single-level CPU interrupt path.
// Revision : 1.0
//==============================================================================
`default_nettype none

module int_controller #(
  parameter int              NSRC     = 4,
  parameter logic [NSRC-1:0] MASK_RST = 4'b0001
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSRC-1:0]          src,
  input  logic                     we_mask,
  input  logic [NSRC-1:0]          mask_in,
  input  logic                     irq_take,
  input  logic                     irq_done,
  output logic                     irq,
  output logic [$clog2(NSRC)-1:0]  irq_id,
  output logic [NSRC-1:0]          pending,
  output logic [NSRC-1:0]          mask,
  output logic [NSRC-1:0]          overflow
);

  localparam int              IDW   = $clog2(NSRC);
  localparam logic [NSRC-1:0] c_ONE = {{(NSRC-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_irq;
  logic             w_irq_nxt;
  logic [IDW-1:0]   r_irq_id;
  logic [IDW-1:0]   w_irq_id_nxt;
  logic [NSRC-1:0]  r_prev;
  logic [NSRC-1:0]  r_pending;
  logic [NSRC-1:0]  r_mask;
  logic [NSRC-1:0]  r_overflow;
  logic [NSRC-1:0]  w_edge;
  logic [NSRC-1:0]  w_eligible;
  logic [NSRC-1:0]  w_clr;
  logic [NSRC-1:0]  w_pending_nxt;
  logic [NSRC-1:0]  w_overflow_nxt;
  logic [IDW-1:0]   w_win_id;
  logic             w_any;
  logic             w_take;

  assign w_edge     = src & ~r_prev;
  assign w_eligible = r_pending & r_mask;
  assign w_any      = |w_eligible;
  assign w_clr      = w_take ? (c_ONE << r_irq_id) : '0;

  // Scan from the top down so the lowest eligible index is the last writer.
  always_comb begin
    w_win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_win_id = IDW'(i);
      end
    end
  end

  // A new edge always wins over a clear on the same cycle; a take-and-edge
  // collision is a fresh event, not a lost one, so it does not flag overflow.
  generate
    for (genvar g = 0; g < NSRC; g++) begin : g_src
      assign w_pending_nxt[g]  = w_edge[g] | (r_pending[g] & ~w_clr[g]);
      assign w_overflow_nxt[g] = r_overflow[g] | (w_edge[g] & r_pending[g] & ~w_clr[g]);
    end
  endgenerate

  always_comb begin
    w_state_nxt  = r_state;
    w_irq_nxt    = r_irq;
    w_irq_id_nxt = r_irq_id;
    w_take       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt  = S_REQ;
          w_irq_nxt    = 1'b1;
          w_irq_id_nxt = w_win_id;
        end
      end
      S_REQ: begin
        if (irq_take) begin
          w_state_nxt = S_SERVICE;
          w_irq_nxt   = 1'b0;
          w_take      = 1'b1;
        end
      end
      S_SERVICE: begin
        if (irq_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_irq_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_irq    <= 1'b0;
      r_irq_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_irq    <= w_irq_nxt;
      r_irq_id <= w_irq_id_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev     <= '0;
      r_pending  <= '0;
      r_overflow <= '0;
      r_mask     <= MASK_RST;
    end else begin
      r_prev     <= src;
      r_pending  <= w_pending_nxt;
      r_overflow <= w_overflow_nxt;
      if (we_mask) begin
        r_mask <= mask_in;
      end
    end
  end

  assign irq      = r_irq;
  assign irq_id   = r_irq_id;
  assign pending  = r_pending;
  assign mask     = r_mask;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_int_controller.sv
//==============================================================================
// Module   : tb_int_controller
// Purpose  : Directed self-checking bench for int_controller.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_int_controller;

  logic       clk;
  logic       reset;
  logic [3:0] src;
  logic       we_mask;
  logic [3:0] mask_in;
  logic       irq_take;
  logic       irq_done;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [3:0] overflow;

  int n_pass;
  int n_total;

  int_controller #(
    .NSRC     (4),
    .MASK_RST (4'b0001)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .src      (src),
    .we_mask  (we_mask),
    .mask_in  (mask_in),
    .irq_take (irq_take),
    .irq_done (irq_done),
    .irq      (irq),
    .irq_id   (irq_id),
    .pending  (pending),
    .mask     (mask),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    reset    = 1'b0;
    src      = 4'b0000;
    we_mask  = 1'b0;
    mask_in  = 4'b0000;
    irq_take = 1'b0;
    irq_done = 1'b0;
    tick();
    tick();
    check("rst_irq",      {3'b0, irq}, 4'b0000);
    check("rst_irq_id",   {2'b0, irq_id}, 4'b0000);
    check("rst_pending",  pending, 4'b0000);
    check("rst_mask",     mask, 4'b0001);
    check("rst_overflow", overflow, 4'b0000);
    reset = 1'b1;
    tick();

    // 1: timer tick -> request -> take -> done
    src = 4'b0001; tick(); src = 4'b0000;
    check("t1_pending",   pending, 4'b0001);
    check("t1_irq_early", {3'b0, irq}, 4'b0000);
    tick();
    check("t1_irq",       {3'b0, irq}, 4'b0001);
    check("t1_irq_id",    {2'b0, irq_id}, 4'b0000);
    tick();
    check("t1_irq_hold",  {3'b0, irq}, 4'b0001);
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    check("t1_take_irq",  {3'b0, irq}, 4'b0000);
    check("t1_take_pend", pending, 4'b0000);
    tick(); tick();
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    check("t1_done_irq",  {3'b0, irq}, 4'b0000);

    // 2: priority between simultaneous sources, back-to-back service
    we_mask = 1'b1; mask_in = 4'b1111; tick(); we_mask = 1'b0;
    check("t2_mask",      mask, 4'b1111);
    src = 4'b1010; tick(); src = 4'b0000;
    check("t2_pending",   pending, 4'b1010);
    tick();
    check("t2_irq",       {3'b0, irq}, 4'b0001);
    check("t2_irq_id",    {2'b0, irq_id}, 4'b0001);
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    check("t2_take_pend", pending, 4'b1000);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    check("t2_gap_irq",   {3'b0, irq}, 4'b0000);
    tick();
    check("t2_b2b_irq",   {3'b0, irq}, 4'b0001);
    check("t2_b2b_id",    {2'b0, irq_id}, 4'b0011);
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    check("t2_pend_clr",  pending, 4'b0000);
    irq_done = 1'b1; tick(); irq_done = 1'b0;

    // 3: masked source pends without requesting until unmasked
    we_mask = 1'b1; mask_in = 4'b0001; tick(); we_mask = 1'b0;
    src = 4'b0100; tick(); src = 4'b0000;
    check("t3_pending",   pending, 4'b0100);
    tick(); tick();
    check("t3_masked",    {3'b0, irq}, 4'b0000);
    we_mask = 1'b1; mask_in = 4'b0101; tick(); we_mask = 1'b0;
    check("t3_mask",      mask, 4'b0101);
    check("t3_irq_early", {3'b0, irq}, 4'b0000);
    tick();
    check("t3_irq",       {3'b0, irq}, 4'b0001);
    check("t3_irq_id",    {2'b0, irq_id}, 4'b0010);
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;

    // 4: edge coinciding with take, then overflow while pending
    src = 4'b0001; tick(); src = 4'b0000;
    tick();
    check("t4_irq",       {3'b0, irq}, 4'b0001);
    src = 4'b0001; irq_take = 1'b1; tick(); irq_take = 1'b0; src = 4'b0000;
    check("t4_set_wins",  pending, 4'b0001);
    check("t4_no_ovf",    overflow, 4'b0000);
    check("t4_take_irq",  {3'b0, irq}, 4'b0000);
    src = 4'b0001; tick(); src = 4'b0000; tick();
    src = 4'b0001; tick(); src = 4'b0000; tick();
    check("t4_overflow",  overflow, 4'b0001);
    check("t4_pend_one",  pending, 4'b0001);

    // 5: service holds off requests; stray handshakes are ignored
    check("t5_svc_hold",  {3'b0, irq}, 4'b0000);
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    check("t5_stray_take_irq",  {3'b0, irq}, 4'b0000);
    check("t5_stray_take_pend", pending, 4'b0001);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    check("t5_done_irq",  {3'b0, irq}, 4'b0000);
    tick();
    check("t5_rearb_irq", {3'b0, irq}, 4'b0001);
    check("t5_rearb_id",  {2'b0, irq_id}, 4'b0000);
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    check("t5_idle_done", {3'b0, irq}, 4'b0000);
    src = 4'b0100; tick(); src = 4'b0000; tick();
    check("t5_after_irq", {3'b0, irq}, 4'b0001);
    check("t5_after_id",  {2'b0, irq_id}, 4'b0010);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    check("t5_req_done",  {3'b0, irq}, 4'b0001);

    // 6: asynchronous reset mid-request, source held high across release
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("t6_async_irq",  {3'b0, irq}, 4'b0000);
    check("t6_async_pend", pending, 4'b0000);
    check("t6_async_mask", mask, 4'b0001);
    check("t6_async_ovf",  overflow, 4'b0000);
    src = 4'b0001;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("t6_rel_pend",  pending, 4'b0001);
    check("t6_rel_irq1",  {3'b0, irq}, 4'b0000);
    tick();
    check("t6_rel_irq2",  {3'b0, irq}, 4'b0001);
    check("t6_rel_id",    {2'b0, irq_id}, 4'b0000);
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    tick();
    check("t6_held_pend", pending, 4'b0000);
    src = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
